// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lsu_ctrl
// Purpose  : Multi-cycle load/store controller for the data-memory access
//            step. It accepts one command, runs a single req/ack transaction,
//            forms store strobes/lane data and extends load results.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst          : clock (rising edge), synchronous active-high reset
//   start/we/funct3   : command strobe, store select, RISC-V width field
//   addr/wdata        : byte address and store data
//   busy/done         : controller occupied / one-cycle completion pulse
//   bus_err/misalign  : completion status, valid only with done
//   mem_rdata         : extended load result for the write-back mux
//   mem_req/mem_we/mem_addr/mem_wdata/mem_wstrb : data-memory bus request
//   mem_ack/mem_rdata_raw                       : data-memory bus response
// Parameters
//   ACK_TIMEOUT : REQ cycles without ack before abort (0 = wait forever)
// Build option
//   LSU_MISALIGN_TRAP_EN : when defined, misaligned halfword/word accesses
//                          complete immediately with misalign=1.
// ============================================================================
module lsu_ctrl #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        bus_err,
  output logic        misalign,
  output logic [31:0] mem_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata_raw
);

  localparam int c_CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam bit c_TO_EN = (ACK_TIMEOUT > 0);
  // Abort fires on the ACK_TIMEOUT-th ack-less REQ cycle.
  localparam logic [c_CNT_W-1:0] c_CNT_LAST =
    c_CNT_W'((ACK_TIMEOUT > 0) ? (ACK_TIMEOUT - 1) : 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_accept;
  logic                w_legal;
  logic                w_misal;
  logic                w_timeout;
  logic                w_err_nxt;
  logic                w_mis_nxt;
  logic                w_load_cap;
  logic [3:0]          w_strb;
  logic [31:0]         w_wdata;
  logic [7:0]          w_byte;
  logic [15:0]         w_half;
  logic [31:0]         w_ld;

  logic [2:0]          r_funct3;
  logic [1:0]          r_off;
  logic                r_mem_we;
  logic [31:0]         r_mem_addr;
  logic [31:0]         r_mem_wdata;
  logic [3:0]          r_mem_wstrb;
  logic [c_CNT_W-1:0]  r_cnt;
  logic                r_bus_err;
  logic                r_misalign;
  logic [31:0]         r_rdata;

  // Command decode and store lane formation (from live inputs at accept)
  always_comb begin
    w_legal = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b010: w_legal = 1'b1;
      3'b100, 3'b101:         w_legal = ~we;   // LBU/LHU have no store form
      default:                w_legal = 1'b0;
    endcase

`ifdef LSU_MISALIGN_TRAP_EN
    w_misal = ((funct3[1:0] == 2'b01) && addr[0]) ||
              ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`else
    w_misal = 1'b0;
`endif

    w_strb  = 4'b0000;
    w_wdata = wdata;
    case (funct3[1:0])
      2'b00: begin
        w_strb  = 4'b0001 << addr[1:0];
        w_wdata = {4{wdata[7:0]}};
      end
      2'b01: begin
        // addr[0] is deliberately ignored for halfwords
        w_strb  = addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{wdata[15:0]}};
      end
      default: begin
        w_strb  = 4'b1111;
        w_wdata = wdata;
      end
    endcase
    if (!we) begin
      w_strb = 4'b0000;
    end
  end

  // Load field extraction from the raw word using the latched offset
  always_comb begin
    w_byte = mem_rdata_raw[7:0];
    case (r_off)
      2'd0: w_byte = mem_rdata_raw[7:0];
      2'd1: w_byte = mem_rdata_raw[15:8];
      2'd2: w_byte = mem_rdata_raw[23:16];
      default: w_byte = mem_rdata_raw[31:24];
    endcase
    w_half = r_off[1] ? mem_rdata_raw[31:16] : mem_rdata_raw[15:0];
    case (r_funct3)
      3'b000:  w_ld = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_ld = {{16{w_half[15]}}, w_half};
      3'b100:  w_ld = {24'd0, w_byte};
      3'b101:  w_ld = {16'd0, w_half};
      default: w_ld = mem_rdata_raw;
    endcase
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_err_nxt   = 1'b0;
    w_mis_nxt   = 1'b0;
    w_load_cap  = 1'b0;
    w_timeout   = c_TO_EN && (r_cnt == c_CNT_LAST);
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          if (!w_legal) begin
            w_state_nxt = S_DONE;
            w_err_nxt   = 1'b1;
          end else if (w_misal) begin
            w_state_nxt = S_DONE;
            w_mis_nxt   = 1'b1;
          end else begin
            w_state_nxt = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          w_state_nxt = S_DONE;
          w_load_cap  = ~r_mem_we;
        end else if (w_timeout) begin
          w_state_nxt = S_DONE;
          w_err_nxt   = 1'b1;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_funct3    <= 3'd0;
      r_off       <= 2'd0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
      r_mem_wstrb <= 4'd0;
      r_cnt       <= '0;
      r_bus_err   <= 1'b0;
      r_misalign  <= 1'b0;
      r_rdata     <= 32'd0;
    end else begin
      r_state    <= w_state_nxt;
      // Status flags are only ever set on entry to DONE, so they self-clear
      r_bus_err  <= w_err_nxt;
      r_misalign <= w_mis_nxt;
      if (w_accept) begin
        r_funct3    <= funct3;
        r_off       <= addr[1:0];
        r_mem_we    <= we;
        r_mem_addr  <= {addr[31:2], 2'b00};
        r_mem_wdata <= w_wdata;
        r_mem_wstrb <= w_strb;
        r_cnt       <= '0;
      end else if ((r_state == S_REQ) && !mem_ack) begin
        r_cnt <= r_cnt + c_CNT_W'(1);
      end
      if (w_load_cap) begin
        r_rdata <= w_ld;
      end
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign mem_req   = (r_state == S_REQ);
  assign bus_err   = r_bus_err;
  assign misalign  = r_misalign;
  assign mem_rdata = r_rdata;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_wstrb = r_mem_wstrb;

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_ctrl
// Purpose  : Self-checking scoreboard bench for lsu_ctrl. Each command pushes
//            its expected completion (cycle, status, load result); a monitor
//            pops and compares on every done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_ctrl;

  localparam int ACK_TO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata_raw = 32'd0;
  logic        busy, done, bus_err, misalign, mem_req, mem_we;
  logic [31:0] mem_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;

  lsu_ctrl #(.ACK_TIMEOUT(ACK_TO)) dut (
    .clk(clk), .rst(rst), .start(start), .we(we), .funct3(funct3),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .bus_err(bus_err),
    .misalign(misalign), .mem_rdata(mem_rdata), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata_raw(mem_rdata_raw)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic        err;
    logic        mis;
    logic [31:0] rdata;
    int          cyc;
  } sb_t;

  sb_t         sb[$];
  logic [31:0] exp_rdata = 32'd0;
  int          n_chk = 0;
  int          n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Reference model of the load/store lane behaviour
  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] off,
                                         input logic [31:0] raw);
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    sh = raw >> (8 * off);
    b  = sh[7:0];
    sh = raw >> (16 * off[1]);
    h  = sh[15:0];
    case (f3)
      3'b000:  return 32'($signed(b));
      3'b001:  return 32'($signed(h));
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return raw;
    endcase
  endfunction

  function automatic logic [3:0] m_strb(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      3'b000:  return 4'b0001 << off;
      3'b001:  return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
    case (f3)
      3'b000:  return {4{wd[7:0]}};
      3'b001:  return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  // Completion monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        if (sb.size() == 0) begin
          chk("spurious_done", 32'd1, 32'd0);
        end else begin
          sb_t e;
          e = sb.pop_front();
          chk("done_cyc", cyc, e.cyc);
          chk("bus_err", bus_err, e.err);
          chk("misalign", misalign, e.mis);
          chk("rdata", mem_rdata, e.rdata);
        end
      end else begin
        chk("flags_nodone", {bus_err, misalign}, 32'd0);
      end
    end
  end

  // One command: dly = ack delay in cycles, negative = never ack.
  // poke re-asserts start (with an illegal funct3) while the controller is busy.
  task automatic do_op(input logic iwe, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] raw, input int dly,
                       input bit poke);
    logic legal, mis, to_bus;
    sb_t  e;
    int   n0, cnt;
    legal = iwe ? (f3 inside {3'b000, 3'b001, 3'b010})
                : (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    mis = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    mis = legal && (((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a[1:0] != 2'b00)));
`endif
    to_bus = legal && !mis;
    n0 = cyc;
    start = 1'b1; we = iwe; funct3 = f3; addr = a; wdata = wd; mem_rdata_raw = raw;
    e.err = !legal || (to_bus && dly < 0);
    e.mis = mis;
    if (to_bus && dly >= 0 && !iwe) exp_rdata = m_load(f3, a[1:0], raw);
    e.rdata = exp_rdata;
    e.cyc = !to_bus ? n0 + 1 : ((dly < 0) ? n0 + 1 + ACK_TO : n0 + 2 + dly);
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    if (!to_bus) begin
      chk("no_req", mem_req, 32'd0);
    end else begin
      chk("req_addr", mem_addr, {a[31:2], 2'b00});
      chk("req_we", mem_we, iwe);
      chk("req_strb", mem_wstrb, iwe ? m_strb(f3, a[1:0]) : 4'b0000);
      if (iwe) chk("req_wdata", mem_wdata, m_wdata(f3, wd));
      if (poke) begin
        start = 1'b1; we = 1'b0; funct3 = 3'b111;
      end
      if (dly >= 0) begin
        for (int i = 0; i <= dly; i++) begin
          if (i > 0) begin
            @(negedge clk);
            start = 1'b0;
          end
          chk("req_hold", {mem_req, mem_addr[31:2]}, {1'b1, a[31:2]});
          mem_ack = (i == dly);
        end
        @(negedge clk);
        start = 1'b0;
        mem_ack = 1'b0;
        chk("req_drop", mem_req, 32'd0);
      end else begin
        cnt = 0;
        while (mem_req && cnt < 100) begin
          cnt++;
          @(negedge clk);
          start = 1'b0;
        end
        chk("to_cycles", cnt, ACK_TO);
      end
    end
    cnt = 0;
    while (busy && cnt < 50) begin
      @(negedge clk);
      start = 1'b0;
      cnt++;
    end
    if (cnt >= 50) chk("idle_wait", 32'd0, 32'd1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", busy, 32'd0);
    chk("rst_done", done, 32'd0);
    chk("rst_req", mem_req, 32'd0);
    chk("rst_rdata", mem_rdata, 32'd0);
    chk("rst_strb", mem_wstrb, 32'd0);
    chk("rst_err", {bus_err, misalign}, 32'd0);

    do_op(1'b0, 3'b000, 32'h0000_0103, 32'd0, 32'h80FF_1234, 0, 1'b0);
    chk("lb_result", mem_rdata, 32'hFFFF_FF80);
    do_op(1'b1, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 32'd0, 0, 1'b0);
    do_op(1'b0, 3'b010, 32'h0000_0040, 32'd0, 32'h1234_5678, 3, 1'b0);
    chk("lw_result", mem_rdata, 32'h1234_5678);
    do_op(1'b0, 3'b010, 32'h0000_0084, 32'd0, 32'hDEAD_BEEF, -1, 1'b0);
    chk("to_hold", mem_rdata, 32'h1234_5678);
    do_op(1'b0, 3'b010, 32'h0000_0041, 32'd0, 32'hCAFE_F00D, 1, 1'b0);
    do_op(1'b0, 3'b001, 32'h0000_0043, 32'd0, 32'h8001_0000, 0, 1'b0);
    do_op(1'b0, 3'b011, 32'h0000_0010, 32'd0, 32'd0, 0, 1'b0);
    do_op(1'b1, 3'b100, 32'h0000_0010, 32'h1111_1111, 32'd0, 0, 1'b0);
    do_op(1'b1, 3'b010, 32'h0000_0010, 32'h5555_AAAA, 32'd0, 2, 1'b1);
    do_op(1'b0, 3'b100, 32'h0000_0012, 32'd0, 32'h00F3_0000, 0, 1'b1);
    do_op(1'b0, 3'b101, 32'h0000_0022, 32'd0, 32'h9ABC_0000, 1, 1'b0);

    // Reset while a request is outstanding
    @(negedge clk);
    start = 1'b1; we = 1'b0; funct3 = 3'b010; addr = 32'h0000_0080;
    @(negedge clk);
    start = 1'b0;
    chk("rst_mid_pre", mem_req, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_req", mem_req, 32'd0);
    chk("rst_mid_busy", busy, 32'd0);
    chk("rst_mid_rdata", mem_rdata, 32'd0);
    rst = 1'b0;
    exp_rdata = 32'd0;
    repeat (2) @(negedge clk);

    for (int k = 0; k < 20; k++) begin
      logic        rwe;
      logic [2:0]  rf3;
      logic [31:0] ra;
      rwe = 1'($urandom_range(0, 1));
      if (rwe) begin
        rf3 = 3'($urandom_range(0, 2));
      end else begin
        case ($urandom_range(0, 4))
          0: rf3 = 3'b000;
          1: rf3 = 3'b001;
          2: rf3 = 3'b010;
          3: rf3 = 3'b100;
          default: rf3 = 3'b101;
        endcase
      end
      ra = $urandom;
      if (rf3[1:0] == 2'b01) ra[0] = 1'b0;
      if (rf3[1:0] == 2'b10) ra[1:0] = 2'b00;
      do_op(rwe, rf3, ra, $urandom, $urandom, $urandom_range(0, 2), 1'b0);
    end

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
